fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 22 ++
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle for fetch_queue: instruction-memory request/response and
// the head-of-queue interface toward the IF/ID register.
interface fetch_queue_if;
    logic        iMemReq;
    logic [63:0] iMemAddr;
    logic        iMemAck;
    logic [31:0] iMemData;
    logic        instValid;
    logic [31:0] instOut;
    logic [63:0] pcOut;
    logic        instReady;

    modport master (
        output iMemReq, iMemAddr, instValid, instOut, pcOut,
        input  iMemAck, iMemData, instReady
    );

    modport slave (
        input  iMemReq, iMemAddr, instValid, instOut, pcOut,
        output iMemAck, iMemData, instReady
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request, DEPTH-entry FIFO of
// {pc, instruction}. Define FETCH_QUEUE_STATS_EN to enable the redirect counter.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [63:0] startPC,
    input  logic        branchTaken,
    input  logic [63:0] branchAddr,
    output logic [15:0] flushCount,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]       state;
    logic [63:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      inst_mem [DEPTH];
    logic [63:0]      pc_mem   [DEPTH];
    logic             inst_valid;
    logic             push;
    logic             pop;
    logic             unused_addr_bits;

    // Reset gates the request and head-valid combinationally so an in-flight
    // request is abandoned in the very cycle Rst rises.
    assign bus.iMemReq   = !Rst && ((state == S_REQ) || (state == S_DISCARD));
    assign bus.iMemAddr  = fetch_pc;
    assign inst_valid    = !Rst && (count != '0);
    assign bus.instValid = inst_valid;
    assign bus.instOut   = inst_valid ? inst_mem[rd_ptr] : '0;
    assign bus.pcOut     = inst_valid ? pc_mem[rd_ptr]   : '0;

    assign pop        = inst_valid && bus.instReady && !branchTaken;
    assign push       = !Rst && (state == S_REQ) && bus.iMemAck && !branchTaken;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    assign unused_addr_bits = &{1'b0, branchAddr[1:0]};

    // NOTE: storage has no reset; outputs are masked by inst_valid instead,
    // which keeps the array out of the reset tree.
    always_ff @(posedge Clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= bus.iMemData;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_IDLE;
            fetch_pc <= startPC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (branchTaken) begin
            // Redirect wins over same-cycle push and pop.
            fetch_pc <= {branchAddr[63:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            if (state == S_REQ)
                state <= bus.iMemAck ? S_IDLE : S_DISCARD;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            case (state)
                S_IDLE:    if (count < FULL) state <= S_REQ;
                S_REQ:     if (bus.iMemAck) state <= (count_next < FULL) ? S_REQ : S_IDLE;
                S_DISCARD: if (bus.iMemAck) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] flush_cnt;

    always_ff @(posedge Clk) begin
        if (Rst)
            flush_cnt <= '0;
        else if (branchTaken && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
    end

    assign flushCount = flush_cnt;
`else
    assign flushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios plus randomized
// redirect/stall/latency traffic against a PC-stream reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [63:0] startPC = 64'h1000;
    logic        branchTaken = 1'b0;
    logic [63:0] branchAddr = '0;
    logic [15:0] flushCount;
    logic        inst_ready = 1'b1;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .startPC    (startPC),
        .branchTaken(branchTaken),
        .branchAddr (branchAddr),
        .flushCount (flushCount),
        .bus        (bus.master)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Memory model: answers each request after a latency drawn from [lat_lo, lat_hi].
    int unsigned lat = 0, wait_cnt = 0, lat_lo = 0, lat_hi = 0;
    assign bus.iMemAck    = bus.iMemReq && (wait_cnt >= lat);
    assign bus.iMemData   = word_of(bus.iMemAddr);
    assign bus.instReady  = inst_ready;

    always @(posedge Clk) begin
        if (Rst || (bus.iMemReq && bus.iMemAck)) begin
            wait_cnt <= 0;
            lat      <= $urandom_range(lat_hi, lat_lo);
        end else if (bus.iMemReq) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Reference model: the expected instruction stream is the sequential PC
    // walk from the last reset/redirect target; one in-flight request may be stale.
    logic [95:0] exp_q[$];
    logic [63:0] model_pc = '0;
    bit          stale = 1'b0;
    bit          prev_rst = 1'b0;
    int          exp_flush = 0;
    int          pops = 0;

    always @(negedge Clk) begin
        if (Rst) begin
            if (prev_rst) begin
                check("rst_iMemReq", bus.iMemReq, 0);
                check("rst_instValid", bus.instValid, 0);
                check("rst_instOut", bus.instOut, 0);
                check("rst_pcOut", bus.pcOut, 0);
                check("rst_flushCount", flushCount, 0);
            end
            exp_q.delete();
            model_pc  = startPC;
            stale     = 1'b0;
            exp_flush = 0;
        end else begin
            check("instValid", bus.instValid, 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("pcOut", bus.pcOut, exp_q[0][95:32]);
                check("instOut", bus.instOut, exp_q[0][31:0]);
            end
            check("flushCount", flushCount, 64'(exp_flush));
            if (bus.iMemReq) check("iMemAddr", bus.iMemAddr, model_pc);
            if (bus.iMemReq && !stale) check("slot_free", 64'(exp_q.size() < DEPTH), 1);

            if (branchTaken) begin
                stale = bus.iMemReq && (stale || !bus.iMemAck);
                exp_q.delete();
                model_pc = {branchAddr[63:2], 2'b00};
`ifdef FETCH_QUEUE_STATS_EN
                if (exp_flush < 16'hFFFF) exp_flush++;
`endif
            end else begin
                if (inst_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
                if (bus.iMemReq && bus.iMemAck) begin
                    if (stale) stale = 1'b0;
                    else begin
                        exp_q.push_back({model_pc, word_of(model_pc)});
                        model_pc = model_pc + 64'd4;
                    end
                end
            end
        end
        prev_rst = Rst;
    end

    initial begin
        int pops_before;
        bit seen;

        // Zero-wait latency and sequential stream.
        step(3);
        Rst = 1'b0;
        step(1);
        check("lat_cycle1_valid", bus.instValid, 0);
        step(1);
        check("lat_cycle2_valid", bus.instValid, 1);
        check("seq_pc0", bus.pcOut, 64'h1000);
        step(1);
        check("seq_pc1", bus.pcOut, 64'h1004);
        step(1);
        check("seq_pc2", bus.pcOut, 64'h1008);

        // Stall until full, then drain in order.
        Rst = 1'b1;
        step(2);
        inst_ready = 1'b0;
        Rst = 1'b0;
        step(10);
        check("full_no_req", bus.iMemReq, 0);
        inst_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_pc", bus.pcOut, 64'h1000 + 64'(4 * i));
            step(1);
        end

        // Redirect together with ack and pop at count=2.
        Rst = 1'b1;
        step(2);
        inst_ready = 1'b0;
        Rst = 1'b0;
        step(3);
        check("pre_flush_valid", bus.instValid, 1);
        inst_ready  = 1'b1;
        branchTaken = 1'b1;
        branchAddr  = 64'h3000;
        step(1);
        branchTaken = 1'b0;
        check("flush_empty", bus.instValid, 0);
        check("flush_no_req", bus.iMemReq, 0);
        check("flush_addr", bus.iMemAddr, 64'h3000);
        step(2);
        check("flush_new_pc", bus.pcOut, 64'h3000);

        // Late memory, redirect during the wait.
        Rst = 1'b1;
        lat_lo = 3;
        lat_hi = 3;
        step(2);
        Rst = 1'b0;
        step(2);
        branchTaken = 1'b1;
        branchAddr  = 64'h2003;
        step(1);
        branchTaken = 1'b0;
        check("discard_req_held", bus.iMemReq, 1);
        check("discard_addr", bus.iMemAddr, 64'h2000);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.instValid) seen = 1'b1;
            else step(1);
        end
        check("discard_first_valid_seen", 64'(seen), 1);
        check("discard_first_pc", bus.pcOut, 64'h2000);

        // 64-bit PC wrap.
        Rst = 1'b1;
        lat_lo = 0;
        lat_hi = 0;
        startPC = 64'hFFFF_FFFF_FFFF_FFFC;
        step(2);
        Rst = 1'b0;
        step(2);
        check("wrap_addr", bus.iMemAddr, 64'h0);
        check("wrap_pc0", bus.pcOut, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1);
        check("wrap_pc1", bus.pcOut, 64'h0);

        // Randomized traffic.
        Rst = 1'b1;
        lat_hi = 3;
        startPC = {32'($urandom), 32'($urandom)} & ~64'h3;
        step(2);
        Rst = 1'b0;
        pops_before = pops;
        for (int i = 0; i < 3000; i++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            branchTaken = ($urandom_range(0, 15) == 0);
            branchAddr  = {32'($urandom), 32'($urandom)};
            Rst         = ($urandom_range(0, 199) == 0);
            step(1);
        end
        Rst = 1'b0;
        branchTaken = 1'b0;
        inst_ready = 1'b1;
        step(10);
        check("random_progress", 64'((pops - pops_before) > 100), 1);

        // Redirect counter.
        Rst = 1'b1;
        step(2);
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            branchTaken = 1'b1;
            branchAddr  = 64'h4000 + 64'(16 * i);
            step(1);
            branchTaken = 1'b0;
            step(1);
        end
`ifdef FETCH_QUEUE_STATS_EN
        check("flushCount_5", flushCount, 5);
`else
        check("flushCount_off", flushCount, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
